// File: rtl/mipi_power_sequencer.sv
// ============================================================================
// Module  : mipi_power_sequencer
// Brief   : Avalon-MM power-up/power-down sequencer for a D8M MIPI camera
//           (MCLK enable -> PWDN_N release -> RESET_N release, timed waits).
//           Optional IRQ support enabled by defining MIPI_SEQ_IRQ_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mipi_power_sequencer #(
  parameter int T_MCLK = 1000,
  parameter int T_PWDN = 5000,
  parameter int T_DOWN = 100,
  parameter int CNT_W  = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        mclk_en,
  output logic        mipi_pwdn_n,
  output logic        mipi_reset_n,
  output logic        busy,
  output logic        irq
);

  typedef enum logic [2:0] {
    S_OFF       = 3'd0,
    S_MCLK_WAIT = 3'd1,
    S_PWDN_WAIT = 3'd2,
    S_ACTIVE    = 3'd3,
    S_DOWN_WAIT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] C_MCLK_LOAD  = CNT_W'(T_MCLK - 1);
  localparam logic [CNT_W-1:0] C_DOWN_LOAD  = CNT_W'(T_DOWN - 1);
  localparam logic [CNT_W-1:0] C_TIMING_RST = CNT_W'(T_PWDN);
  localparam logic [CNT_W-1:0] C_ONE        = CNT_W'(1);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [CNT_W-1:0]   r_timing;
  logic               r_mclk_en, w_mclk_en_nxt;
  logic               r_pwdn_n, w_pwdn_n_nxt;
  logic               r_reset_n, w_reset_n_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_set;
  logic               r_pwr_req;
  logic               w_wr;
  logic               w_irq_mask;
  logic               w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_unused = &{1'b0, writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_OFF;
      r_cnt     <= '0;
      r_mclk_en <= 1'b0;
      r_pwdn_n  <= 1'b0;
      r_reset_n <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pwr_req <= 1'b0;
      r_timing  <= C_TIMING_RST;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_mclk_en <= w_mclk_en_nxt;
      r_pwdn_n  <= w_pwdn_n_nxt;
      r_reset_n <= w_reset_n_nxt;
      r_busy    <= w_busy_nxt;
      // A completion event in the same cycle as a W1C must not be lost
      if (w_done_set)
        r_done <= 1'b1;
      else if (w_wr && address == 2'd1 && writedata[4])
        r_done <= 1'b0;
      if (w_wr && address == 2'd0)
        r_pwr_req <= writedata[0];
      if (w_wr && address == 2'd2)
        r_timing <= (writedata[CNT_W-1:0] == '0) ? C_ONE : writedata[CNT_W-1:0];
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_mclk_en_nxt = r_mclk_en;
    w_pwdn_n_nxt  = r_pwdn_n;
    w_reset_n_nxt = r_reset_n;
    w_done_set    = 1'b0;
    case (r_state)
      S_OFF: begin
        w_mclk_en_nxt = 1'b0;
        w_pwdn_n_nxt  = 1'b0;
        w_reset_n_nxt = 1'b0;
        if (r_pwr_req) begin
          w_mclk_en_nxt = 1'b1;
          w_cnt_nxt     = C_MCLK_LOAD;
          w_state_nxt   = S_MCLK_WAIT;
        end
      end
      S_MCLK_WAIT: begin
        if (r_cnt == '0) begin
          w_pwdn_n_nxt = 1'b1;
          w_cnt_nxt    = r_timing - C_ONE;
          w_state_nxt  = S_PWDN_WAIT;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      S_PWDN_WAIT: begin
        if (r_cnt == '0) begin
          w_reset_n_nxt = 1'b1;
          w_done_set    = 1'b1;
          w_state_nxt   = S_ACTIVE;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      S_ACTIVE: begin
        if (!r_pwr_req) begin
          w_reset_n_nxt = 1'b0;
          w_cnt_nxt     = C_DOWN_LOAD;
          w_state_nxt   = S_DOWN_WAIT;
        end
      end
      S_DOWN_WAIT: begin
        if (r_cnt == '0) begin
          w_pwdn_n_nxt  = 1'b0;
          w_mclk_en_nxt = 1'b0;
          w_done_set    = 1'b1;
          w_state_nxt   = S_OFF;
        end else begin
          w_cnt_nxt = r_cnt - C_ONE;
        end
      end
      default: begin
        w_mclk_en_nxt = 1'b0;
        w_pwdn_n_nxt  = 1'b0;
        w_reset_n_nxt = 1'b0;
        w_state_nxt   = S_OFF;
      end
    endcase
    w_busy_nxt = (w_state_nxt == S_MCLK_WAIT) || (w_state_nxt == S_PWDN_WAIT) ||
                 (w_state_nxt == S_DOWN_WAIT);
  end

`ifdef MIPI_SEQ_IRQ_EN
  logic r_irq_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_irq_mask <= 1'b0;
    else if (w_wr && address == 2'd0)
      r_irq_mask <= writedata[1];
  end

  assign w_irq_mask = r_irq_mask;
  assign irq        = r_done & r_irq_mask;
`else
  assign w_irq_mask = 1'b0;
  assign irq        = 1'b0;
`endif

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0:    readdata = {30'd0, w_irq_mask, r_pwr_req};
      2'd1:    readdata = {27'd0, r_done, r_busy, r_state};
      2'd2:    readdata = 32'(r_timing);
      default: readdata = 32'd0;
    endcase
  end

  assign mclk_en      = r_mclk_en;
  assign mipi_pwdn_n  = r_pwdn_n;
  assign mipi_reset_n = r_reset_n;
  assign busy         = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_mipi_power_sequencer.sv
// ============================================================================
// Module  : tb_mipi_power_sequencer
// Brief   : Directed self-checking bench for mipi_power_sequencer
//           (T_MCLK=4, TIMING=8, T_DOWN=3).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mipi_power_sequencer;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        mclk_en;
  logic        mipi_pwdn_n;
  logic        mipi_reset_n;
  logic        busy;
  logic        irq;

  int checks = 0;
  int errors = 0;

  mipi_power_sequencer #(
    .T_MCLK(4),
    .T_PWDN(8),
    .T_DOWN(3),
    .CNT_W (24)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .mclk_en     (mclk_en),
    .mipi_pwdn_n (mipi_pwdn_n),
    .mipi_reset_n(mipi_reset_n),
    .busy        (busy),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ordering invariant checked every cycle
  always @(negedge clk) begin
    checks++;
    if ((mipi_reset_n && !mipi_pwdn_n) || (mipi_pwdn_n && !mclk_en)) begin
      errors++;
      $display("FAIL ordering: mclk_en=%0b pwdn_n=%0b reset_n=%0b required reset_n->pwdn_n->mclk_en",
               mclk_en, mipi_pwdn_n, mipi_reset_n);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Write is captured at the posedge this task waits for; returns 1ns after it
  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    #12;
    checks++;
    if ({mclk_en, mipi_pwdn_n, mipi_reset_n, busy, irq} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 00000", {mclk_en, mipi_pwdn_n, mipi_reset_n, busy, irq});
    end
    address = 2'd1; #1;
    checks++;
    if (readdata !== 32'h0) begin
      errors++; $display("FAIL reset_status: got %h required 00000000", readdata);
    end
    address = 2'd2; #1;
    checks++;
    if (readdata !== 32'd8) begin
      errors++; $display("FAIL reset_timing: got %h required 00000008", readdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick(2);
  endtask

  task automatic test_power_up;
    write_reg(2'd0, 32'h1);
    checks++;
    if (mclk_en !== 1'b0) begin
      errors++; $display("FAIL up_mclk_pre: got %b required 0", mclk_en);
    end
    tick(1);
    address = 2'd1; #1;
    checks++;
    if ({mclk_en, mipi_pwdn_n, mipi_reset_n, busy} !== 4'b1001 || readdata !== 32'h09) begin
      errors++;
      $display("FAIL up_mclk: got outs=%b status=%h required 1001 00000009",
               {mclk_en, mipi_pwdn_n, mipi_reset_n, busy}, readdata);
    end
    tick(3);
    checks++;
    if (mipi_pwdn_n !== 1'b0) begin
      errors++; $display("FAIL up_pwdn_early: got %b required 0", mipi_pwdn_n);
    end
    tick(1);
    address = 2'd1; #1;
    checks++;
    if ({mipi_pwdn_n, mipi_reset_n} !== 2'b10 || readdata !== 32'h0A) begin
      errors++;
      $display("FAIL up_pwdn: got pwdn/reset=%b status=%h required 10 0000000a",
               {mipi_pwdn_n, mipi_reset_n}, readdata);
    end
    tick(7);
    checks++;
    if (mipi_reset_n !== 1'b0) begin
      errors++; $display("FAIL up_reset_early: got %b required 0", mipi_reset_n);
    end
    tick(1);
    address = 2'd1; #1;
    checks++;
    if ({mclk_en, mipi_pwdn_n, mipi_reset_n, busy} !== 4'b1110 || readdata !== 32'h13) begin
      errors++;
      $display("FAIL up_active: got outs=%b status=%h required 1110 00000013",
               {mclk_en, mipi_pwdn_n, mipi_reset_n, busy}, readdata);
    end
  endtask

  task automatic test_power_down;
    write_reg(2'd0, 32'h0);
    tick(1);
    address = 2'd1; #1;
    checks++;
    if ({mclk_en, mipi_pwdn_n, mipi_reset_n, busy} !== 4'b1101 || readdata !== 32'h1C) begin
      errors++;
      $display("FAIL down_start: got outs=%b status=%h required 1101 0000001c",
               {mclk_en, mipi_pwdn_n, mipi_reset_n, busy}, readdata);
    end
    tick(2);
    checks++;
    if ({mclk_en, mipi_pwdn_n} !== 2'b11) begin
      errors++; $display("FAIL down_early: got %b required 11", {mclk_en, mipi_pwdn_n});
    end
    tick(1);
    address = 2'd1; #1;
    checks++;
    if ({mclk_en, mipi_pwdn_n, mipi_reset_n, busy} !== 4'b0000 || readdata !== 32'h10) begin
      errors++;
      $display("FAIL down_off: got outs=%b status=%h required 0000 00000010",
               {mclk_en, mipi_pwdn_n, mipi_reset_n, busy}, readdata);
    end
  endtask

  task automatic test_regs;
    write_reg(2'd1, 32'h10);
    address = 2'd1; #1;
    checks++;
    if (readdata !== 32'h0) begin
      errors++; $display("FAIL done_w1c: got %h required 00000000", readdata);
    end
    write_reg(2'd3, 32'hFFFF_FFFF);
    address = 2'd3; #1;
    checks++;
    if (readdata !== 32'h0) begin
      errors++; $display("FAIL addr3: got %h required 00000000", readdata);
    end
    @(negedge clk);
    address = 2'd2; writedata = 32'h55; chipselect = 1'b0; write_n = 1'b0;
    tick(1);
    write_n = 1'b1; #1;
    checks++;
    if (readdata !== 32'd8) begin
      errors++; $display("FAIL no_cs_write: got %h required 00000008", readdata);
    end
    write_reg(2'd2, 32'hFF00_0000);
    address = 2'd2; #1;
    checks++;
    if (readdata !== 32'd1) begin
      errors++; $display("FAIL timing_zero: got %h required 00000001", readdata);
    end
  endtask

  task automatic test_timing_one;
    write_reg(2'd0, 32'h1);
    tick(5);
    checks++;
    if ({mipi_pwdn_n, mipi_reset_n} !== 2'b10) begin
      errors++; $display("FAIL t1_pwdn: got %b required 10", {mipi_pwdn_n, mipi_reset_n});
    end
    tick(1);
    checks++;
    if (mipi_reset_n !== 1'b1) begin
      errors++; $display("FAIL t1_reset: got %b required 1", mipi_reset_n);
    end
    write_reg(2'd0, 32'h0);
    tick(4);
    write_reg(2'd2, 32'd8);
    write_reg(2'd1, 32'h10);
  endtask

  task automatic test_timing_mid_pwdn;
    write_reg(2'd0, 32'h1);
    tick(5);
    write_reg(2'd2, 32'd2);
    tick(6);
    checks++;
    if (mipi_reset_n !== 1'b0) begin
      errors++; $display("FAIL tmid_early: got %b required 0", mipi_reset_n);
    end
    tick(1);
    address = 2'd2; #1;
    checks++;
    if (mipi_reset_n !== 1'b1 || readdata !== 32'd2) begin
      errors++; $display("FAIL tmid_active: got reset_n=%b timing=%h required 1 00000002", mipi_reset_n, readdata);
    end
    write_reg(2'd0, 32'h0);
    tick(4);
    write_reg(2'd2, 32'd8);
    write_reg(2'd1, 32'h10);
  endtask

  task automatic test_back_to_back;
    write_reg(2'd0, 32'h1);
    tick(1);
    write_reg(2'd0, 32'h0);
    tick(3);
    checks++;
    if ({mclk_en, mipi_pwdn_n, mipi_reset_n} !== 3'b110) begin
      errors++; $display("FAIL b2b_pwdn: got %b required 110", {mclk_en, mipi_pwdn_n, mipi_reset_n});
    end
    tick(8);
    address = 2'd1; #1;
    checks++;
    if (mipi_reset_n !== 1'b1 || readdata !== 32'h13) begin
      errors++; $display("FAIL b2b_active: got reset_n=%b status=%h required 1 00000013", mipi_reset_n, readdata);
    end
    tick(1);
    address = 2'd1; #1;
    checks++;
    if (mipi_reset_n !== 1'b0 || readdata !== 32'h1C) begin
      errors++; $display("FAIL b2b_down: got reset_n=%b status=%h required 0 0000001c", mipi_reset_n, readdata);
    end
    tick(3);
    checks++;
    if ({mclk_en, mipi_pwdn_n, mipi_reset_n, busy} !== 4'b0000) begin
      errors++; $display("FAIL b2b_off: got %b required 0000", {mclk_en, mipi_pwdn_n, mipi_reset_n, busy});
    end
    write_reg(2'd1, 32'h10);
  endtask

  task automatic test_irq;
    write_reg(2'd0, 32'h3);
    address = 2'd0; #1;
`ifdef MIPI_SEQ_IRQ_EN
    checks++;
    if (readdata !== 32'h3) begin
      errors++; $display("FAIL irq_ctrl: got %h required 00000003", readdata);
    end
    tick(12);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_early: got %b required 0", irq);
    end
    tick(1);
    checks++;
    if (irq !== 1'b1 || mipi_reset_n !== 1'b1) begin
      errors++; $display("FAIL irq_rise: got irq=%b reset_n=%b required 1 1", irq, mipi_reset_n);
    end
    write_reg(2'd1, 32'h10);
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL irq_clear: got %b required 0", irq);
    end
`else
    checks++;
    if (readdata !== 32'h1) begin
      errors++; $display("FAIL irq_ctrl: got %h required 00000001", readdata);
    end
    tick(13);
    checks++;
    if (irq !== 1'b0 || mipi_reset_n !== 1'b1) begin
      errors++; $display("FAIL irq_tied: got irq=%b reset_n=%b required 0 1", irq, mipi_reset_n);
    end
`endif
  endtask

  task automatic test_reset_mid;
    write_reg(2'd0, 32'h0);
    tick(4);
    write_reg(2'd1, 32'h10);
    write_reg(2'd2, 32'd5);
    write_reg(2'd0, 32'h1);
    tick(7);
    checks++;
    if ({mclk_en, mipi_pwdn_n, mipi_reset_n, busy} !== 4'b1101) begin
      errors++; $display("FAIL rmid_pre: got %b required 1101", {mclk_en, mipi_pwdn_n, mipi_reset_n, busy});
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mclk_en, mipi_pwdn_n, mipi_reset_n, busy, irq} !== 5'b0) begin
      errors++; $display("FAIL rmid_outs: got %b required 00000", {mclk_en, mipi_pwdn_n, mipi_reset_n, busy, irq});
    end
    address = 2'd0; #1;
    checks++;
    if (readdata !== 32'h0) begin
      errors++; $display("FAIL rmid_ctrl: got %h required 00000000", readdata);
    end
    address = 2'd2; #1;
    checks++;
    if (readdata !== 32'd8) begin
      errors++; $display("FAIL rmid_timing: got %h required 00000008", readdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick(3);
    checks++;
    if ({mclk_en, mipi_pwdn_n, mipi_reset_n, busy} !== 4'b0000) begin
      errors++; $display("FAIL rmid_stay_off: got %b required 0000", {mclk_en, mipi_pwdn_n, mipi_reset_n, busy});
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_regs();
    test_timing_one();
    test_timing_mid_pwdn();
    test_back_to_back();
    test_irq();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
